// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the simple_mips memory arbiter.
package mips_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 18;

  typedef enum logic {
    ArbIdle,
    ArbBusy
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnIf,
    OwnD
  } arb_owner_e;

endpackage

// File: rtl/mips_arb_starve_ctr.sv
// Saturating counter of consecutive data grants taken while a fetch is waiting.
module mips_arb_starve_ctr #(
  parameter int unsigned Max = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int unsigned W = $clog2(Max + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(Max))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == W'(Max));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store; data wins unless
// the fetch side has been starved for StarveMax consecutive data grants.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned AddrW     = MEM_ADDR_W,
  parameter int unsigned Latency   = 1,
  parameter int unsigned StarveMax = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             if_req_i,
  input  logic [AddrW-1:0] if_addr_i,
  output logic             if_gnt_o,
  output logic             if_rvalid_o,
  output logic [31:0]      if_rdata_o,
  input  logic             d_req_i,
  input  logic             d_we_i,
  input  logic [3:0]       d_be_i,
  input  logic [AddrW-1:0] d_addr_i,
  input  logic [31:0]      d_wdata_i,
  output logic             d_gnt_o,
  output logic             d_rvalid_o,
  output logic [31:0]      d_rdata_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  localparam int unsigned CntW = $clog2(Latency + 1);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             store_q, store_d;

  logic slot_open, rsp_fire, starve_sat;
  logic d_win, if_win;

  assign slot_open = (state_q == ArbIdle) || (cnt_q == CntW'(1));
  // Outputs are gated by reset so an in-flight response is dropped immediately.
  assign rsp_fire  = !reset_i && (state_q == ArbBusy) && (cnt_q == CntW'(1));

  always_comb begin
    d_win  = 1'b0;
    if_win = 1'b0;
    if (!reset_i && slot_open) begin
      if (d_req_i && !(if_req_i && starve_sat)) begin
        d_win = 1'b1;
      end else if (if_req_i) begin
        if_win = 1'b1;
      end
    end
  end

  mips_arb_starve_ctr #(
    .Max (StarveMax)
  ) u_starve (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (d_win && if_req_i),
    .clr_i   (if_win || !if_req_i),
    .sat_o   (starve_sat)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ArbIdle;
      owner_q <= OwnNone;
      cnt_q   <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    if (d_win || if_win) begin
      state_d = ArbBusy;
      owner_d = d_win ? OwnD : OwnIf;
      cnt_d   = CntW'(Latency);
      store_d = d_win && d_we_i;
    end else if (state_q == ArbBusy) begin
      if (cnt_q == CntW'(1)) begin
        state_d = ArbIdle;
        owner_d = OwnNone;
        cnt_d   = '0;
        store_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    if_gnt_o    = if_win;
    d_gnt_o     = d_win;
    mem_en_o    = d_win || if_win;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    if (d_win) begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (if_win) begin
      mem_be_o    = 4'hF;
      mem_addr_o  = if_addr_i;
    end
    if (rsp_fire) begin
      case (owner_q)
        OwnIf: begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = mem_rdata_i;
        end
        OwnD: begin
          d_rvalid_o = 1'b1;
          d_rdata_o  = store_q ? 32'h0 : mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench: a Latency=1 arbiter for most scenarios and a Latency=3 one for pipelining.
module tb_mips_mem_arbiter;

  localparam int unsigned AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic          a_if_req, a_if_gnt, a_if_rvalid;
  logic [AW-1:0] a_if_addr;
  logic [31:0]   a_if_rdata;
  logic          a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
  logic [3:0]    a_d_be;
  logic [AW-1:0] a_d_addr;
  logic [31:0]   a_d_wdata, a_d_rdata;
  logic          a_mem_en, a_mem_we;
  logic [3:0]    a_mem_be;
  logic [AW-1:0] a_mem_addr;
  logic [31:0]   a_mem_wdata, a_mem_rdata;

  logic          b_if_req, b_if_gnt, b_if_rvalid;
  logic [AW-1:0] b_if_addr;
  logic [31:0]   b_if_rdata;
  logic          b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
  logic [3:0]    b_d_be;
  logic [AW-1:0] b_d_addr;
  logic [31:0]   b_d_wdata, b_d_rdata;
  logic          b_mem_en, b_mem_we;
  logic [3:0]    b_mem_be;
  logic [AW-1:0] b_mem_addr;
  logic [31:0]   b_mem_wdata, b_mem_rdata;

  mips_mem_arbiter #(.AddrW(AW), .Latency(1), .StarveMax(4)) u_a (
    .clk_i(clk), .reset_i(reset),
    .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_gnt_o(a_if_gnt),
    .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata),
    .d_req_i(a_d_req), .d_we_i(a_d_we), .d_be_i(a_d_be), .d_addr_i(a_d_addr),
    .d_wdata_i(a_d_wdata), .d_gnt_o(a_d_gnt), .d_rvalid_o(a_d_rvalid), .d_rdata_o(a_d_rdata),
    .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
  );

  mips_mem_arbiter #(.AddrW(AW), .Latency(3), .StarveMax(4)) u_b (
    .clk_i(clk), .reset_i(reset),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_gnt_o(b_if_gnt),
    .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
    .d_req_i(b_d_req), .d_we_i(b_d_we), .d_be_i(b_d_be), .d_addr_i(b_d_addr),
    .d_wdata_i(b_d_wdata), .d_gnt_o(b_d_gnt), .d_rvalid_o(b_d_rvalid), .d_rdata_o(b_d_rdata),
    .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  // Memory models: read data appears exactly Latency cycles after mem_en, garbage otherwise.
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic [31:0] pipe_b [0:2];

  always @(posedge clk) begin
    if (a_mem_en) begin
      a_mem_rdata <= mem_a[a_mem_addr[9:0]];
      if (a_mem_we) begin
        for (int i = 0; i < 4; i++) begin
          if (a_mem_be[i]) mem_a[a_mem_addr[9:0]][8*i +: 8] <= a_mem_wdata[8*i +: 8];
        end
      end
    end else begin
      a_mem_rdata <= 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk) begin
    pipe_b[0] <= b_mem_en ? mem_b[b_mem_addr[9:0]] : 32'hDEAD_BEEF;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_mem_rdata = pipe_b[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    mem_a[0] <= 32'h3C01_0010;
    mem_a[5] <= 32'h1122_3344;
    mem_a[6] <= 32'hCAFE_F00D;
    mem_b[0] <= 32'h3C01_0010;
    mem_b[1] <= 32'h2402_0005;
    reset = 1'b1;
    a_if_req = 0; a_if_addr = '0; a_d_req = 0; a_d_we = 0; a_d_be = 0; a_d_addr = '0;
    a_d_wdata = 0;
    b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_be = 0; b_d_addr = '0;
    b_d_wdata = 0;

    // Reset: no grant even with a request pending
    @(negedge clk);
    a_if_req = 1; a_if_addr = 18'h04000;
    #1 chk("rst_if_gnt", {31'b0, a_if_gnt}, 0);
    chk("rst_mem_en", {31'b0, a_mem_en}, 0);
    step();
    reset = 0; a_if_req = 0;
    #1 chk("idle_ctl", {24'b0, a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we,
                        2'b0}, 0);
    chk("idle_be", {28'b0, a_mem_be}, 0);
    chk("idle_rdata", a_if_rdata | a_d_rdata, 0);

    // 1. Lone fetch
    step();
    a_if_req = 1; a_if_addr = 18'h04000;
    #1 chk("t1_if_gnt", {31'b0, a_if_gnt}, 1);
    chk("t1_mem_be", {28'b0, a_mem_be}, 4'hF);
    chk("t1_mem_addr", {14'b0, a_mem_addr}, 32'h04000);
    step();
    a_if_req = 0;
    #1 chk("t1_if_rvalid", {31'b0, a_if_rvalid}, 1);
    chk("t1_if_rdata", a_if_rdata, 32'h3C01_0010);
    step();
    #1 chk("t1_rvalid_pulse", {31'b0, a_if_rvalid}, 0);

    // 2. Simultaneous load and fetch: data first
    step();
    a_if_req = 1; a_if_addr = 18'h04000; a_d_req = 1; a_d_we = 0; a_d_be = 4'hF;
    a_d_addr = 18'd6;
    #1 chk("t2_gnts", {30'b0, a_d_gnt, a_if_gnt}, 2'b10);
    step();
    a_d_req = 0;
    #1 chk("t2_gnts_b", {30'b0, a_d_gnt, a_if_gnt}, 2'b01);
    chk("t2_d_rvalid", {31'b0, a_d_rvalid}, 1);
    chk("t2_d_rdata", a_d_rdata, 32'hCAFE_F00D);
    step();
    a_if_req = 0;
    #1 chk("t2_if_rdata", a_if_rdata, 32'h3C01_0010);
    chk("t2_rvalids", {30'b0, a_if_rvalid, a_d_rvalid}, 2'b10);
    step();

    // 3. Starvation: D,D,D,D,IF,D,D,D,D,IF
    a_if_req = 1; a_d_req = 1; a_d_we = 0; a_d_addr = 18'd6;
    for (int i = 0; i < 10; i++) begin
      #1 chk($sformatf("t3_gnt%0d", i), {30'b0, a_d_gnt, a_if_gnt},
             (i == 4 || i == 9) ? 32'd1 : 32'd2);
      step();
    end
    a_if_req = 0; a_d_req = 0;
    #1 chk("t3_last_rvalid", {30'b0, a_if_rvalid, a_d_rvalid}, 2'b10);
    step();

    // 4. Byte store
    a_d_req = 1; a_d_we = 1; a_d_be = 4'b0010; a_d_addr = 18'd5; a_d_wdata = 32'h0000_AB00;
    #1 chk("t4_d_gnt", {31'b0, a_d_gnt}, 1);
    chk("t4_mem_we_be", {27'b0, a_mem_we, a_mem_be}, 5'b1_0010);
    step();
    a_d_req = 0; a_d_we = 0;
    #1 chk("t4_d_rvalid", {31'b0, a_d_rvalid}, 1);
    chk("t4_d_rdata", a_d_rdata, 0);
    chk("t4_mem_word", mem_a[5], 32'h1122_AB44);
    step();

    // 6. Reset the cycle after a load grant
    a_d_req = 1; a_d_be = 4'hF; a_d_addr = 18'd6;
    #1 chk("t6_d_gnt", {31'b0, a_d_gnt}, 1);
    step();
    reset = 1; a_d_req = 0;
    #1 chk("t6_no_rvalid", {31'b0, a_d_rvalid}, 0);
    chk("t6_rdata", a_d_rdata, 0);
    step();
    reset = 0;
    #1 chk("t6_outs", {26'b0, a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we},
           0);
    step();
    a_if_req = 1; a_if_addr = 18'h04000;
    #1 chk("t6_if_gnt", {31'b0, a_if_gnt}, 1);
    step();
    a_if_req = 0;
    #1 chk("t6_if_rdata", a_if_rdata, 32'h3C01_0010);

    // 5. Latency=3 back-to-back fetches
    step();
    b_if_req = 1; b_if_addr = 18'h04000;
    #1 chk("t5_gnt_T", {31'b0, b_if_gnt}, 1);
    for (int i = 1; i <= 2; i++) begin
      step();
      #1 chk($sformatf("t5_quiet_T%0d", i), {30'b0, b_if_gnt, b_if_rvalid}, 0);
    end
    step();
    b_if_addr = 18'h04001;
    #1 chk("t5_T3", {30'b0, b_if_gnt, b_if_rvalid}, 2'b11);
    chk("t5_rdata1", b_if_rdata, 32'h3C01_0010);
    step();
    b_if_req = 0;
    #1 chk("t5_T4", {31'b0, b_if_rvalid}, 0);
    step();
    #1 chk("t5_T5", {31'b0, b_if_rvalid}, 0);
    step();
    #1 chk("t5_T6", {31'b0, b_if_rvalid}, 1);
    chk("t5_rdata2", b_if_rdata, 32'h2402_0005);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
